// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, immediate format tags and the output buffer state
// encoding for the ID-stage immediate generator.
package imm_gen_pkg;

  // Major opcodes, inst[6:0]
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] STORE_FP = 7'b0100111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] OP_FP    = 7'b1010011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  // Immediate format carried alongside the value
  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6,
    IMM_CSR   = 3'd7
  } imm_type_e;

  // Occupancy of the 2-entry output buffer
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: extracts the immediate of any base/F
// instruction, extends it to XLEN and reports its format and legality.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit ZIMM_EN = 1'b1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic            illegal
);

  // RV64 shift amounts carry one extra bit
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [6:0] opcode;
  logic [2:0] funct3;

  // Raw fields held as signed so the size casts below sign-extend to XLEN
  logic signed [11:0] raw_i;
  logic signed [11:0] raw_s;
  logic signed [12:0] raw_b;
  logic signed [20:0] raw_j;
  logic signed [31:0] raw_u;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_shamt;
  logic [XLEN-1:0] imm_csr;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  assign raw_i = inst[31:20];
  assign raw_s = {inst[31:25], inst[11:7]};
  assign raw_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign raw_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign raw_u = {inst[31:12], 12'b0};

  assign imm_i     = XLEN'(raw_i);
  assign imm_s     = XLEN'(raw_s);
  assign imm_b     = XLEN'(raw_b);
  assign imm_j     = XLEN'(raw_j);
  assign imm_u     = XLEN'(raw_u);
  assign imm_shamt = XLEN'(inst[SHW+19:20]);
  // CSR*I forms (funct3[2]=1) expose the 5-bit zimm when enabled, else the CSR address
  assign imm_csr   = (ZIMM_EN && funct3[2]) ? XLEN'(inst[19:15]) : XLEN'(inst[31:20]);

  // Select immediate and format by opcode; anything unknown is flagged illegal with a zero immediate
  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    if (inst[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        LOAD, LOAD_FP, JALR: begin
          imm      = imm_i;
          imm_type = IMM_I;
        end
        OP_IMM: begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            imm      = imm_shamt;
            imm_type = IMM_SHAMT;
          end else begin
            imm      = imm_i;
            imm_type = IMM_I;
          end
        end
        STORE, STORE_FP: begin
          imm      = imm_s;
          imm_type = IMM_S;
        end
        BRANCH: begin
          imm      = imm_b;
          imm_type = IMM_B;
        end
        JAL: begin
          imm      = imm_j;
          imm_type = IMM_J;
        end
        LUI, AUIPC: begin
          imm      = imm_u;
          imm_type = IMM_U;
        end
        SYSTEM: begin
          imm      = imm_csr;
          imm_type = IMM_CSR;
        end
        OP, OP_FP: begin
          imm      = '0;
          imm_type = IMM_NONE;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes on the input handshake, adds the PC
// to form the target and parks results in a 2-entry FIFO so EX can stall or
// flush without losing ordering.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit ZIMM_EN = 1'b1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_type_e        out_type,
  output logic [XLEN-1:0]  out_target,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_target;

  buf_state_e state_reg;
  buf_state_e state_next;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic       push;
  logic       pop;

  imm_decode #(
    .XLEN    (XLEN),
    .ZIMM_EN (ZIMM_EN)
  ) u_decode (
    .inst     (in_inst),
    .imm      (dec_imm),
    .imm_type (dec_type),
    .illegal  (dec_illegal)
  );

  // Illegal and NONE entries carry a zero immediate, so their target is simply the PC
  assign dec_target = in_pc + dec_imm;

  // Handshake flags depend only on the registered occupancy
  assign in_ready  = (state_reg != BUF_FULL);
  assign out_valid = (state_reg != BUF_EMPTY);
  // Flush drops a same-cycle input and cancels any pop
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= BUF_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Occupancy next-state: flush empties, otherwise track push/pop
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = BUF_EMPTY;
    end else begin
      case (state_reg)
        BUF_EMPTY: if (push) state_next = BUF_ONE;
        BUF_ONE: begin
          if (push && !pop)      state_next = BUF_FULL;
          else if (pop && !push) state_next = BUF_EMPTY;
        end
        BUF_FULL:  if (pop) state_next = BUF_ONE;
        default:   state_next = BUF_EMPTY;
      endcase
    end
  end

  // Read/write pointers; both realign to slot 0 whenever the buffer is emptied by force
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : gen_entry
    logic [XLEN-1:0]  imm_reg;
    imm_type_e        type_reg;
    logic [XLEN-1:0]  target_reg;
    logic             illegal_reg;
    logic [TAG_W-1:0] tag_reg;

    // Capture decoded result into this slot when it is the write target
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        imm_reg     <= '0;
        type_reg    <= IMM_NONE;
        target_reg  <= '0;
        illegal_reg <= 1'b0;
        tag_reg     <= '0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        imm_reg     <= dec_imm;
        type_reg    <= dec_type;
        target_reg  <= dec_target;
        illegal_reg <= dec_illegal;
        tag_reg     <= in_tag;
      end
    end
  end

  // Head-of-queue view, forced to zero when empty so stale entries never leak out
  always_comb begin
    out_imm     = '0;
    out_type    = IMM_NONE;
    out_target  = '0;
    out_illegal = 1'b0;
    out_tag     = '0;
    if (out_valid) begin
      if (rd_ptr_reg) begin
        out_imm     = gen_entry[1].imm_reg;
        out_type    = gen_entry[1].type_reg;
        out_target  = gen_entry[1].target_reg;
        out_illegal = gen_entry[1].illegal_reg;
        out_tag     = gen_entry[1].tag_reg;
      end else begin
        out_imm     = gen_entry[0].imm_reg;
        out_type    = gen_entry[0].type_reg;
        out_target  = gen_entry[0].target_reg;
        out_illegal = gen_entry[0].illegal_reg;
        out_tag     = gen_entry[0].tag_reg;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (RV32 with zimm, RV32
// without zimm, RV64) share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm, a_out_target;
  logic [2:0]  a_out_type;
  logic [3:0]  a_out_tag;

  logic        z_in_ready, z_out_valid, z_out_illegal;
  logic [31:0] z_out_imm, z_out_target;
  logic [2:0]  z_out_type;
  logic [3:0]  z_out_tag;

  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [63:0] w_out_imm, w_out_target;
  logic [2:0]  w_out_type;
  logic [3:0]  w_out_tag;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.XLEN(32), .ZIMM_EN(1'b1), .TAG_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .in_tag(in_tag), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_imm(a_out_imm), .out_type(a_out_type),
    .out_target(a_out_target), .out_illegal(a_out_illegal), .out_tag(a_out_tag)
  );

  imm_gen_pipe #(.XLEN(32), .ZIMM_EN(1'b0), .TAG_W(4)) dut_z (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .in_tag(in_tag), .out_valid(z_out_valid),
    .out_ready(out_ready), .out_imm(z_out_imm), .out_type(z_out_type),
    .out_target(z_out_target), .out_illegal(z_out_illegal), .out_tag(z_out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .ZIMM_EN(1'b1), .TAG_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_tag(in_tag), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_imm(w_out_imm), .out_type(w_out_type),
    .out_target(w_out_target), .out_illegal(w_out_illegal), .out_tag(w_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One accepted instruction; returns 1 time unit after the capturing edge
  task automatic send(input logic [31:0] i, input logic [63:0] pc, input logic [3:0] t);
    in_valid = 1'b1;
    in_inst  = i;
    in_pc    = pc;
    in_tag   = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("txn inst=%h pc=%h tag=%0d imm32=%h type=%0d tgt32=%h ill=%0d imm64=%h",
             i, pc, t, a_out_imm, a_out_type, a_out_target, a_out_illegal, w_out_imm);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_tag = '0;
    out_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_imm", a_out_imm, 0);
    chk("rst_out_tag", a_out_tag, 0);
    chk("rst_in_ready64", w_in_ready, 1);
    chk("rst_out_valid64", w_out_valid, 0);

    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // LUI
    send(32'h123450B7, 64'h0, 4'd1);
    chk("lui_valid", a_out_valid, 1);
    chk("lui_imm", a_out_imm, 64'h12345000);
    chk("lui_type", a_out_type, 4);
    chk("lui_illegal", a_out_illegal, 0);
    chk("lui_tag", a_out_tag, 1);
    chk("lui_imm64", w_out_imm, 64'h12345000);

    // JAL -4
    send(32'hFFDFF06F, 64'h100, 4'd2);
    chk("jal_imm", a_out_imm, 64'hFFFFFFFC);
    chk("jal_type", a_out_type, 5);
    chk("jal_target", a_out_target, 64'hFC);
    chk("jal_imm64", w_out_imm, 64'hFFFFFFFFFFFFFFFC);
    chk("jal_target64", w_out_target, 64'hFC);
    chk("jal_type64", w_out_type, 5);

    // CSRRWI csr 0x300, zimm 5
    send(32'h3002D073, 64'h1000, 4'd3);
    chk("csr_imm_zimm", a_out_imm, 64'h5);
    chk("csr_type", a_out_type, 7);
    chk("csr_target", a_out_target, 64'h1005);
    chk("csr_imm_nozimm", z_out_imm, 64'h300);
    chk("csr_target_nozimm", z_out_target, 64'h1300);
    chk("csr_type_nozimm", z_out_type, 7);
    chk("csr_valid_nozimm", z_out_valid, 1);
    chk("csr_ready_nozimm", z_in_ready, 1);
    chk("csr_illegal_nozimm", z_out_illegal, 0);
    chk("csr_tag_nozimm", z_out_tag, 3);

    // SLLI shamt 31
    send(32'h01F09093, 64'h0, 4'd4);
    chk("slli_imm", a_out_imm, 64'h1F);
    chk("slli_type", a_out_type, 6);
    chk("slli_imm64", w_out_imm, 64'h1F);

    // SW imm -4
    send(32'hFE112E23, 64'h0, 4'd5);
    chk("sw_imm", a_out_imm, 64'hFFFFFFFC);
    chk("sw_type", a_out_type, 2);

    // BEQ +8 from 0x200
    send(32'h00000463, 64'h200, 4'd6);
    chk("beq_imm", a_out_imm, 64'h8);
    chk("beq_type", a_out_type, 3);
    chk("beq_target", a_out_target, 64'h208);

    // ADD (R-type): no immediate, legal
    send(32'h002081B3, 64'h80, 4'd7);
    chk("add_imm", a_out_imm, 0);
    chk("add_type", a_out_type, 0);
    chk("add_illegal", a_out_illegal, 0);
    chk("add_target", a_out_target, 64'h80);

    // RV64 LUI with bit 31 set
    send(32'h800000B7, 64'h0, 4'd8);
    chk("lui64_imm", w_out_imm, 64'hFFFFFFFF80000000);
    chk("lui32_imm", a_out_imm, 64'h80000000);

    // All-zero instruction is illegal
    send(32'h00000000, 64'h40, 4'd9);
    chk("ill_flag", a_out_illegal, 1);
    chk("ill_imm", a_out_imm, 0);
    chk("ill_type", a_out_type, 0);
    chk("ill_target", a_out_target, 64'h40);
    chk("ill_flag64", w_out_illegal, 1);
    chk("ill_imm64", w_out_imm, 0);
    chk("ill_tag64", w_out_tag, 9);

    // Drain
    tick();
    chk("drain_valid", a_out_valid, 0);

    // Back-pressure: tags 1,2,3 with consumer stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h123450B7; in_pc = '0;
    in_tag = 4'd1; tick();
    chk("bp_ready_1", a_in_ready, 1);
    chk("bp_tag_1", a_out_tag, 1);
    in_tag = 4'd2; tick();
    chk("bp_ready_full", a_in_ready, 0);
    chk("bp_head_stable", a_out_tag, 1);
    in_tag = 4'd3; tick();
    chk("bp_still_full", a_in_ready, 0);
    chk("bp_head_hold", a_out_tag, 1);
    chk("bp_imm_hold", a_out_imm, 64'h12345000);
    out_ready = 1'b1; tick();
    chk("bp_pop_tag2", a_out_tag, 2);
    chk("bp_ready_again", a_in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_pop_tag3", a_out_tag, 3);
    chk("bp_valid_3", a_out_valid, 1);
    tick();
    chk("bp_empty", a_out_valid, 0);

    // Flush with two buffered and a same-cycle input
    out_ready = 1'b0;
    send(32'h123450B7, 64'h0, 4'd4);
    send(32'h123450B7, 64'h0, 4'd5);
    chk("fl_full", a_in_ready, 0);
    flush = 1'b1; in_valid = 1'b1; in_tag = 4'd6;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", a_out_valid, 0);
    chk("fl_ready", a_in_ready, 1);
    chk("fl_tag", a_out_tag, 0);
    chk("fl_valid64", w_out_valid, 0);
    out_ready = 1'b1;
    tick();
    chk("fl_nothing_out", a_out_valid, 0);

    // Reset mid-operation
    out_ready = 1'b0;
    send(32'hFFDFF06F, 64'h100, 4'd11);
    chk("mr_before", a_out_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("mr_valid", a_out_valid, 0);
    chk("mr_imm", a_out_imm, 0);
    chk("mr_target", a_out_target, 0);
    chk("mr_ready", a_in_ready, 1);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
